dsp_job_scheduler: RTL and testbench

Arbitrates two requesters (software start path from the DSP register slave, hardware trigger path) for the single DSP equation engine and sequences each job through launch, completion wait, and release. Launches the engine with a one-cycle start pulse and an equation select. Detects completion on the engine's done edge or aborts on timeout. Returns a per-requester ack or error pulse and keeps a saturating timeout counter for the status register.

---
 rtl/dsp_job_scheduler_pkg.sv | 31 +++
 rtl/dsp_rr_arbiter.sv | 21 ++
 rtl/dsp_job_scheduler.sv | 116 +++++++++++
 tb/tb_dsp_job_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_job_scheduler_pkg.sv
// Shared constants for the DSP job scheduler: FSM encodings,
// default timeout and the status field seen through the DSP slave.
package dsp_job_scheduler_pkg;

  localparam int unsigned DSP_SCHED_TIMEOUT = 1024;

  localparam logic [2:0] DSP_SCHED_IDLE    = 3'd0;
  localparam logic [2:0] DSP_SCHED_LAUNCH  = 3'd1;
  localparam logic [2:0] DSP_SCHED_WAIT    = 3'd2;
  localparam logic [2:0] DSP_SCHED_DONE    = 3'd3;
  localparam logic [2:0] DSP_SCHED_RELEASE = 3'd4;

  // Scheduler field of the DSP slave status word.
  typedef struct packed {
    logic [22:0] rsvd;
    logic        busy;
    logic [7:0]  timeout_cnt;
  } dsp_sched_status_t;

  function automatic dsp_sched_status_t dsp_sched_status(
    input logic       busy,
    input logic [7:0] timeout_cnt
  );
    dsp_sched_status_t s;
    s.rsvd        = '0;
    s.busy        = busy;
    s.timeout_cnt = timeout_cnt;
    return s;
  endfunction

endpackage

// File: rtl/dsp_rr_arbiter.sv
// 2-way round-robin arbiter, purely combinational.
// Ports: req (request vector), last (index served last), grant (one-hot).
module dsp_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // The requester not served last gets first pick.
  always_comb begin
    grant = 2'b00;
    if (last) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/dsp_job_scheduler.sv
// Sequences jobs from two requesters onto the single DSP equation engine.
// Ports: wb_clk/wb_rst_n (sync active-low), req_i/reqN_eq_i/abort_i in,
// dsp_done_i from engine; dsp_start_o/dsp_eq_o to engine; grant_o,
// ack_o, err_o to requesters; busy_o, timeout_cnt_o for status.
module dsp_job_scheduler
  import dsp_job_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = DSP_SCHED_TIMEOUT,
  parameter int unsigned EQW     = 4
) (
  input  logic           wb_clk,
  input  logic           wb_rst_n,
  input  logic [1:0]     req_i,
  input  logic [EQW-1:0] req0_eq_i,
  input  logic [EQW-1:0] req1_eq_i,
  input  logic           abort_i,
  input  logic           dsp_done_i,
  output logic           dsp_start_o,
  output logic [EQW-1:0] dsp_eq_o,
  output logic [1:0]     grant_o,
  output logic [1:0]     ack_o,
  output logic [1:0]     err_o,
  output logic           busy_o,
  output logic [7:0]     timeout_cnt_o
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [2:0]  state;
  logic [15:0] timer;
  logic        last;
  logic        done_q;
  logic        done_edge;
  logic [1:0]  win;

  assign done_edge = dsp_done_i & ~done_q;

  dsp_rr_arbiter u_arb (
    .req   (req_i),
    .last  (last),
    .grant (win)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state         <= DSP_SCHED_IDLE;
      timer         <= '0;
      last          <= 1'b1;
      done_q        <= 1'b0;
      dsp_start_o   <= 1'b0;
      dsp_eq_o      <= '0;
      grant_o       <= 2'b00;
      ack_o         <= 2'b00;
      err_o         <= 2'b00;
      busy_o        <= 1'b0;
      timeout_cnt_o <= 8'd0;
    end else begin
      done_q      <= dsp_done_i;
      dsp_start_o <= 1'b0;
      ack_o       <= 2'b00;
      err_o       <= 2'b00;
      case (state)
        DSP_SCHED_IDLE: begin
          if (|win) begin
            grant_o     <= win;
            dsp_eq_o    <= win[1] ? req1_eq_i : req0_eq_i;
            busy_o      <= 1'b1;
            dsp_start_o <= 1'b1;
            state       <= DSP_SCHED_LAUNCH;
          end
        end
        DSP_SCHED_LAUNCH: begin
          // A done edge here belongs to a previous job; ignore it.
          timer <= TMO;
          if (abort_i) begin
            err_o <= grant_o;
            state <= DSP_SCHED_DONE;
          end else begin
            state <= DSP_SCHED_WAIT;
          end
        end
        DSP_SCHED_WAIT: begin
          if (done_edge) begin
            ack_o <= grant_o;
            state <= DSP_SCHED_DONE;
          end else if (abort_i) begin
            err_o <= grant_o;
            state <= DSP_SCHED_DONE;
          end else if (timer == 16'd0) begin
            err_o <= grant_o;
            state <= DSP_SCHED_DONE;
            if (timeout_cnt_o != 8'hFF)
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DSP_SCHED_DONE: begin
          // Outputs are registered, so clear here to be low in RELEASE.
          last     <= grant_o[1];
          grant_o  <= 2'b00;
          dsp_eq_o <= '0;
          busy_o   <= 1'b0;
          state    <= DSP_SCHED_RELEASE;
        end
        DSP_SCHED_RELEASE: begin
          state <= DSP_SCHED_IDLE;
        end
        default: begin
          state <= DSP_SCHED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_job_scheduler.sv
// Scoreboard bench for dsp_job_scheduler with TIMEOUT=16.
// Expected launch/response records are queued; negedge monitors compare.
module tb_dsp_job_scheduler;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       wb_rst_n;
  logic [1:0] req_i;
  logic [3:0] req0_eq_i;
  logic [3:0] req1_eq_i;
  logic       abort_i;
  logic       dsp_done_i;
  logic       dsp_start_o;
  logic [3:0] dsp_eq_o;
  logic [1:0] grant_o;
  logic [1:0] ack_o;
  logic [1:0] err_o;
  logic       busy_o;
  logic [7:0] timeout_cnt_o;

  always #5 clk = ~clk;

  dsp_job_scheduler #(.TIMEOUT(T), .EQW(4)) dut (
    .wb_clk        (clk),
    .wb_rst_n      (wb_rst_n),
    .req_i         (req_i),
    .req0_eq_i     (req0_eq_i),
    .req1_eq_i     (req1_eq_i),
    .abort_i       (abort_i),
    .dsp_done_i    (dsp_done_i),
    .dsp_start_o   (dsp_start_o),
    .dsp_eq_o      (dsp_eq_o),
    .grant_o       (grant_o),
    .ack_o         (ack_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  typedef struct packed {
    logic [1:0] grant;
    logic [3:0] eq;
  } st_t;

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
    logic [1:0] grant;
    logic [3:0] eq;
    logic [7:0] tc;
  } rs_t;

  st_t sq[$];
  rs_t rq[$];
  st_t es;
  rs_t er;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: launch pulses and ack/err pulses against queued records.
  always @(negedge clk) begin
    if (wb_rst_n === 1'b1) begin
      if (dsp_start_o) begin
        if (sq.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          es = sq.pop_front();
          chk("start_grant", 32'(grant_o), 32'(es.grant));
          chk("start_eq", 32'(dsp_eq_o), 32'(es.eq));
        end
      end
      if ((ack_o | err_o) != 2'b00) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          er = rq.pop_front();
          chk("resp_ack", 32'(ack_o), 32'(er.ack));
          chk("resp_err", 32'(err_o), 32'(er.err));
          chk("resp_grant", 32'(grant_o), 32'(er.grant));
          chk("resp_eq", 32'(dsp_eq_o), 32'(er.eq));
          chk("resp_tcnt", 32'(timeout_cnt_o), 32'(er.tc));
        end
      end
    end
  end

  // One job: queue expectations, wait for launch, drive done/abort at
  // given cycle offsets after launch, then release the requester.
  task automatic run_job(input logic [1:0] g, input logic [3:0] eq,
                         input int fall_at, input int rise_at,
                         input int abort_at, input logic ok,
                         input logic [7:0] tc, input int exp_c);
    st_t s;
    rs_t r;
    int  c;
    bit  seen;
    s.grant = g;
    s.eq    = eq;
    sq.push_back(s);
    r.ack   = ok ? g : 2'b00;
    r.err   = ok ? 2'b00 : g;
    r.grant = g;
    r.eq    = eq;
    r.tc    = tc;
    rq.push_back(r);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = dsp_start_o;
    end
    if (!seen) begin
      chk("start_seen", 0, 1);
      return;
    end
    chk("busy_on", 32'(busy_o), 1);
    c    = 0;
    seen = 0;
    while (!seen && c < 200) begin
      tick();
      c++;
      if (c == 1) chk("start_width", 32'(dsp_start_o), 0);
      seen = (ack_o | err_o) != 2'b00;
      if (!seen) begin
        if (c == fall_at) dsp_done_i = 1'b0;
        if (c == rise_at) dsp_done_i = 1'b1;
        abort_i = (c == abort_at);
      end
    end
    if (!seen) begin
      chk("job_end_seen", 0, 1);
      return;
    end
    chk("job_latency", c, exp_c);
    req_i      = req_i & ~g;
    abort_i    = 1'b0;
    dsp_done_i = 1'b0;
    tick();
    chk("pulse_width", 32'(ack_o | err_o), 0);
    chk("grant_released", 32'(grant_o), 0);
    chk("busy_released", 32'(busy_o), 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_n   = 1'b0;
    req_i      = 2'b00;
    req0_eq_i  = 4'd3;
    req1_eq_i  = 4'd9;
    abort_i    = 1'b0;
    dsp_done_i = 1'b0;
    repeat (3) tick();
    chk("rst_start", 32'(dsp_start_o), 0);
    chk("rst_eq", 32'(dsp_eq_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_tcnt", 32'(timeout_cnt_o), 0);
    wb_rst_n = 1'b1;
    tick();

    // Single job, done edge ten cycles after launch.
    req_i = 2'b01;
    run_job(2'b01, 4'd3, -1, 9, -1, 1'b1, 8'd0, 10);

    // Both requesting: round-robin alternation.
    req_i = 2'b11;
    run_job(2'b10, 4'd9, -1, 2, -1, 1'b1, 8'd0, 3);
    req_i = 2'b11;
    run_job(2'b01, 4'd3, -1, 2, -1, 1'b1, 8'd0, 3);
    req_i = 2'b11;
    run_job(2'b10, 4'd9, -1, 2, -1, 1'b1, 8'd0, 3);
    req_i = 2'b11;
    run_job(2'b01, 4'd3, -1, 2, -1, 1'b1, 8'd0, 3);
    req_i = 2'b00;

    // Abort in the third WAIT cycle.
    req_i = 2'b01;
    run_job(2'b01, 4'd3, -1, -1, 3, 1'b0, 8'd0, 4);

    // Done edge coincides with timer expiry: success.
    req_i = 2'b10;
    run_job(2'b10, 4'd9, -1, T + 1, -1, 1'b1, 8'd0, T + 2);

    // Done already high before launch: no edge, timeout.
    dsp_done_i = 1'b1;
    tick();
    tick();
    req_i = 2'b01;
    run_job(2'b01, 4'd3, -1, -1, -1, 1'b0, 8'd1, T + 2);

    // Done high, falls, rises again in WAIT: ack on the edge.
    dsp_done_i = 1'b1;
    tick();
    tick();
    req_i = 2'b10;
    run_job(2'b10, 4'd9, 2, 4, -1, 1'b1, 8'd1, 5);

    // Remaining timeouts to drive the counter into saturation.
    for (int i = 0; i < 299; i++) begin
      req_i = 2'b01;
      run_job(2'b01, 4'd3, -1, -1, -1, 1'b0,
              (i + 2 > 255) ? 8'd255 : 8'(i + 2), T + 2);
    end
    chk("tcnt_saturated", 32'(timeout_cnt_o), 255);

    // Reset in the middle of WAIT.
    req_i = 2'b11;
    es.grant = 2'b10;
    es.eq    = 4'd9;
    sq.push_back(es);
    for (int i = 0; i < 20 && !dsp_start_o; i++) tick();
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy_o), 1);
    wb_rst_n = 1'b0;
    tick();
    chk("mid_rst_start", 32'(dsp_start_o), 0);
    chk("mid_rst_eq", 32'(dsp_eq_o), 0);
    chk("mid_rst_grant", 32'(grant_o), 0);
    chk("mid_rst_ack", 32'(ack_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_tcnt", 32'(timeout_cnt_o), 0);
    wb_rst_n = 1'b1;
    run_job(2'b01, 4'd3, -1, 2, -1, 1'b1, 8'd0, 3);
    req_i = 2'b00;

    repeat (5) tick();
    chk("start_queue_empty", sq.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
